// File: rtl/board_pkg.sv
// Shared types and constants for the battleship board renderer.
package board_pkg;

    // Cell state codes double as the ship_rom tile bases (code << 5).
    typedef enum logic [1:0] {
        CELL_SHIP  = 2'b00,
        CELL_EMPTY = 2'b01,
        CELL_HIT   = 2'b10,
        CELL_MISS  = 2'b11
    } cell_state_t;

    // Clear sequencer states.
    typedef enum logic {
        SEQ_IDLE  = 1'b0,
        SEQ_CLEAR = 1'b1
    } seq_state_t;

    localparam int BOARD_N    = 10;
    localparam int CELL_SIZE  = 32;
    localparam int CELL_SHIFT = 5;
    localparam int BOARD_PX   = 320;
    localparam int CELL_COUNT = BOARD_N * BOARD_N;

    // Linear cell index y*10 + x, built from shifts so it stays 7 bits wide.
    function automatic logic [6:0] cell_index(input logic [3:0] col, input logic [3:0] row);
        logic [6:0] w_row7;
        logic [6:0] w_col7;
        w_row7 = {3'b000, row};
        w_col7 = {3'b000, col};
        return (w_row7 << 3) + (w_row7 << 1) + w_col7;
    endfunction

endpackage

// File: rtl/board_cell_mem.sv
// 100 x 2-bit board state memory with a game-logic write port,
// a bulk-clear sequencer and one combinational read port.
module board_cell_mem
    import board_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic [1:0] wr_state,
    input  logic       clr,
    input  logic [6:0] rd_idx,
    output logic [1:0] rd_state,
    output logic       busy
);

    logic [1:0] r_cells [0:CELL_COUNT-1];
    seq_state_t r_state;
    seq_state_t w_state_nxt;
    logic [6:0] r_clr_idx;
    logic [6:0] w_clr_idx_nxt;
    logic       r_busy;
    logic       w_wr_ok;
    logic [6:0] w_wr_idx;

    // Game writes are accepted only for on-board coordinates while no clear runs.
    assign w_wr_ok  = wr_en && (wr_x <= 4'd9) && (wr_y <= 4'd9) && !r_busy;
    assign w_wr_idx = cell_index(wr_x, wr_y);

    // Out-of-range read indices never occur from the top, but return EMPTY to stay defined.
    assign rd_state = (rd_idx < 7'd100) ? r_cells[rd_idx] : CELL_EMPTY;
    assign busy     = r_busy;

    // Cell storage: reset fills EMPTY at once, clear writes one cell per cycle, else game write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CELL_COUNT; i++) begin
                r_cells[i] <= CELL_EMPTY;
            end
        end else if (r_busy) begin
            r_cells[r_clr_idx] <= CELL_EMPTY;
        end else if (w_wr_ok) begin
            r_cells[w_wr_idx] <= wr_state;
        end
    end

    // Sequencer state, clear index and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SEQ_IDLE;
            r_clr_idx <= 7'd0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_busy    <= (w_state_nxt == SEQ_CLEAR);
        end
    end

    // Next-state logic: a clr pulse (re)starts the sweep at cell 0; cell 99 ends it.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            SEQ_IDLE: begin
                if (clr) begin
                    w_state_nxt   = SEQ_CLEAR;
                    w_clr_idx_nxt = 7'd0;
                end else begin
                    w_state_nxt   = SEQ_IDLE;
                    w_clr_idx_nxt = 7'd0;
                end
            end
            SEQ_CLEAR: begin
                if (clr) begin
                    w_state_nxt   = SEQ_CLEAR;
                    w_clr_idx_nxt = 7'd0;
                end else if (r_clr_idx == 7'd99) begin
                    w_state_nxt   = SEQ_IDLE;
                    w_clr_idx_nxt = 7'd0;
                end else begin
                    w_state_nxt   = SEQ_CLEAR;
                    w_clr_idx_nxt = r_clr_idx + 7'd1;
                end
            end
            default: begin
                w_state_nxt   = SEQ_IDLE;
                w_clr_idx_nxt = 7'd0;
            end
        endcase
    end

endmodule

// File: rtl/board_draw.sv
// Renders a 10x10 battleship board into the VGA pixel stream.
// Stage 1 looks up the cell and drives the ship_rom address, stage 2 waits
// for the ROM line, stage 3 picks the pixel bit and composes the colour.
module board_draw
    import board_pkg::*;
#(
    parameter logic [10:0] X_ORIGIN  = 11'd64,
    parameter logic [10:0] Y_ORIGIN  = 11'd64,
    parameter logic [11:0] COL_SHIP  = 12'h888,
    parameter logic [11:0] COL_EMPTY = 12'h00F,
    parameter logic [11:0] COL_HIT   = 12'hF00,
    parameter logic [11:0] COL_MISS  = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [6:0]  rom_addr,
    input  logic [31:0] rom_pixels,
    input  logic        wr_en,
    input  logic [3:0]  wr_x,
    input  logic [3:0]  wr_y,
    input  logic [1:0]  wr_state,
    input  logic        clr,
    output logic        busy,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    // Stage-0 coordinate math.
    logic [10:0] w_dx;
    logic [10:0] w_dy;
    logic        w_in_board;
    logic [6:0]  w_rd_idx;
    logic [1:0]  w_cell_state;
    logic [6:0]  w_rom_addr;

    // Stage 1 and stage 2 delay registers.
    logic [6:0]  r_rom_addr;
    logic [10:0] r_s1_hcount, r_s2_hcount;
    logic [10:0] r_s1_vcount, r_s2_vcount;
    logic        r_s1_hsync, r_s2_hsync;
    logic        r_s1_vsync, r_s2_vsync;
    logic        r_s1_hblnk, r_s2_hblnk;
    logic        r_s1_vblnk, r_s2_vblnk;
    logic [11:0] r_s1_rgb, r_s2_rgb;
    logic        r_s1_in_board, r_s2_in_board;
    logic [4:0]  r_s1_col, r_s2_col;
    logic [1:0]  r_s1_state, r_s2_state;

    // Stage 3 output registers.
    logic [10:0] r_hcount_out;
    logic [10:0] r_vcount_out;
    logic        r_hsync_out;
    logic        r_vsync_out;
    logic        r_hblnk_out;
    logic        r_vblnk_out;
    logic [11:0] r_rgb_out;

    logic        w_pix_bit;
    logic [11:0] w_fg;
    logic [11:0] w_rgb_nxt;

    board_cell_mem u_mem (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_state (wr_state),
        .clr      (clr),
        .rd_idx   (w_rd_idx),
        .rd_state (w_cell_state),
        .busy     (busy)
    );

    // Unsigned wrap makes positions left of / above the origin fail the < 320 test too.
    assign w_dx       = hcount_in - X_ORIGIN;
    assign w_dy       = vcount_in - Y_ORIGIN;
    assign w_in_board = (hcount_in >= X_ORIGIN) && (w_dx < 11'(BOARD_PX)) &&
                        (vcount_in >= Y_ORIGIN) && (w_dy < 11'(BOARD_PX));
    // Inside the board dx[9:5] is at most 9, so bits [8:5] carry the whole cell number.
    assign w_rd_idx   = w_in_board ? cell_index(w_dx[8:5], w_dy[8:5]) : 7'd0;
    assign w_rom_addr = w_in_board ? {w_cell_state, w_dy[4:0]} : {CELL_EMPTY, 5'd0};

    // Stage 1: ROM address plus copies of everything the colour mux needs later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr    <= 7'd0;
            r_s1_hcount   <= 11'd0;
            r_s1_vcount   <= 11'd0;
            r_s1_hsync    <= 1'b0;
            r_s1_vsync    <= 1'b0;
            r_s1_hblnk    <= 1'b0;
            r_s1_vblnk    <= 1'b0;
            r_s1_rgb      <= 12'd0;
            r_s1_in_board <= 1'b0;
            r_s1_col      <= 5'd0;
            r_s1_state    <= 2'd0;
        end else begin
            r_rom_addr    <= w_rom_addr;
            r_s1_hcount   <= hcount_in;
            r_s1_vcount   <= vcount_in;
            r_s1_hsync    <= hsync_in;
            r_s1_vsync    <= vsync_in;
            r_s1_hblnk    <= hblnk_in;
            r_s1_vblnk    <= vblnk_in;
            r_s1_rgb      <= rgb_in;
            r_s1_in_board <= w_in_board;
            r_s1_col      <= w_dx[4:0];
            r_s1_state    <= w_cell_state;
        end
    end

    // Stage 2: hold stage-1 data while ship_rom registers the tile line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_hcount   <= 11'd0;
            r_s2_vcount   <= 11'd0;
            r_s2_hsync    <= 1'b0;
            r_s2_vsync    <= 1'b0;
            r_s2_hblnk    <= 1'b0;
            r_s2_vblnk    <= 1'b0;
            r_s2_rgb      <= 12'd0;
            r_s2_in_board <= 1'b0;
            r_s2_col      <= 5'd0;
            r_s2_state    <= 2'd0;
        end else begin
            r_s2_hcount   <= r_s1_hcount;
            r_s2_vcount   <= r_s1_vcount;
            r_s2_hsync    <= r_s1_hsync;
            r_s2_vsync    <= r_s1_vsync;
            r_s2_hblnk    <= r_s1_hblnk;
            r_s2_vblnk    <= r_s1_vblnk;
            r_s2_rgb      <= r_s1_rgb;
            r_s2_in_board <= r_s1_in_board;
            r_s2_col      <= r_s1_col;
            r_s2_state    <= r_s1_state;
        end
    end

    // MSB of the ROM line is the leftmost pixel of the tile.
    assign w_pix_bit = rom_pixels[5'd31 - r_s2_col];

    // Foreground colour chosen by the cell state that produced this ROM line.
    always_comb begin
        w_fg = COL_EMPTY;
        case (r_s2_state)
            CELL_SHIP:  w_fg = COL_SHIP;
            CELL_EMPTY: w_fg = COL_EMPTY;
            CELL_HIT:   w_fg = COL_HIT;
            CELL_MISS:  w_fg = COL_MISS;
            default:    w_fg = COL_EMPTY;
        endcase
    end

    // Overlay only lit tile pixels inside the board and outside blanking.
    always_comb begin
        w_rgb_nxt = r_s2_rgb;
        if (r_s2_in_board && w_pix_bit && !r_s2_hblnk && !r_s2_vblnk) begin
            w_rgb_nxt = w_fg;
        end else begin
            w_rgb_nxt = r_s2_rgb;
        end
    end

    // Stage 3: registered pixel and timing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcount_out <= 11'd0;
            r_vcount_out <= 11'd0;
            r_hsync_out  <= 1'b0;
            r_vsync_out  <= 1'b0;
            r_hblnk_out  <= 1'b0;
            r_vblnk_out  <= 1'b0;
            r_rgb_out    <= 12'd0;
        end else begin
            r_hcount_out <= r_s2_hcount;
            r_vcount_out <= r_s2_vcount;
            r_hsync_out  <= r_s2_hsync;
            r_vsync_out  <= r_s2_vsync;
            r_hblnk_out  <= r_s2_hblnk;
            r_vblnk_out  <= r_s2_vblnk;
            r_rgb_out    <= w_rgb_nxt;
        end
    end

    assign rom_addr   = r_rom_addr;
    assign hcount_out = r_hcount_out;
    assign vcount_out = r_vcount_out;
    assign hsync_out  = r_hsync_out;
    assign vsync_out  = r_vsync_out;
    assign hblnk_out  = r_hblnk_out;
    assign vblnk_out  = r_vblnk_out;
    assign rgb_out    = r_rgb_out;

endmodule

// File: tb/tb_board_draw.sv
// Self-checking bench for board_draw: ship_rom model, board/pipeline reference
// model, directed vector table, hand-written clear sequences and random traffic.
module tb_board_draw;

    localparam int X0 = 64;
    localparam int Y0 = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [6:0]  rom_addr;
    logic [31:0] rom_pixels = 32'd0;
    logic        wr_en;
    logic [3:0]  wr_x, wr_y;
    logic [1:0]  wr_state;
    logic        clr;
    logic        busy;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    board_draw dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .rom_addr(rom_addr), .rom_pixels(rom_pixels),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_state(wr_state),
        .clr(clr), .busy(busy),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    // ship_rom stand-in: even tile rows light the left 16 pixels, odd rows the right 16.
    function automatic logic [31:0] rom_line(input logic [6:0] a);
        return a[0] ? 32'h0000_FFFF : 32'hFFFF_0000;
    endfunction

    // Registered ROM, one cycle of latency like ship_rom.
    always @(posedge clk) rom_pixels <= rom_line(rom_addr);

    function automatic logic [11:0] colour(input logic [1:0] st);
        case (st)
            2'b00:   return 12'h888;
            2'b01:   return 12'h00F;
            2'b10:   return 12'hF00;
            default: return 12'hFFF;
        endcase
    endfunction

    // Reference model: board contents and clear progress (-1 = idle).
    logic [1:0] m_cells [0:99];
    int         m_clr_pos = -1;

    typedef struct packed {
        logic [6:0]  addr;
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } exp_t;

    exp_t pipe [0:2];

    // Expected rom_addr and final outputs for the pixel currently on the inputs.
    function automatic exp_t model_pixel();
        exp_t e;
        int h, v, cx, cy, row, col;
        logic [1:0]  st;
        logic [31:0] line;
        h = int'(hcount_in);
        v = int'(vcount_in);
        e.hc = hcount_in; e.vc = vcount_in;
        e.hs = hsync_in;  e.vs = vsync_in;
        e.hb = hblnk_in;  e.vb = vblnk_in;
        e.rgb  = rgb_in;
        e.addr = 7'h20;
        if (h >= X0 && h < X0 + 320 && v >= Y0 && v < Y0 + 320) begin
            cx = (h - X0) / 32;  cy = (v - Y0) / 32;
            col = (h - X0) % 32; row = (v - Y0) % 32;
            st = m_cells[cy * 10 + cx];
            e.addr = {st, 5'(row)};
            line = rom_line(e.addr);
            if (line[31 - col] && !hblnk_in && !vblnk_in) e.rgb = colour(st);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One clock: predict, advance the model across the edge, then compare everything.
    task automatic tick();
        exp_t e;
        e = model_pixel();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            for (int i = 0; i < 100; i++) m_cells[i] = 2'b01;
            m_clr_pos = -1;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e;
            if (m_clr_pos >= 0) begin
                m_cells[m_clr_pos] = 2'b01;
                if (clr) m_clr_pos = 0;
                else if (m_clr_pos == 99) m_clr_pos = -1;
                else m_clr_pos++;
            end else begin
                if (wr_en && wr_x <= 4'd9 && wr_y <= 4'd9)
                    m_cells[int'(wr_y) * 10 + int'(wr_x)] = wr_state;
                if (clr) m_clr_pos = 0;
            end
        end
        @(negedge clk);
        chk("rom_addr", 64'(rom_addr), 64'(pipe[0].addr));
        chk("outputs", 64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out}),
            64'({pipe[2].hc, pipe[2].vc, pipe[2].hs, pipe[2].vs, pipe[2].hb, pipe[2].vb, pipe[2].rgb}));
        chk("busy", 64'(busy), 64'(m_clr_pos >= 0));
    endtask

    task automatic set_pix(input int h, input int v, input logic [11:0] c, input logic hb);
        hcount_in = 11'(h); vcount_in = 11'(v); rgb_in = c; hblnk_in = hb;
    endtask

    task automatic write_cell(input int x, input int y, input logic [1:0] st);
        wr_en = 1'b1; wr_x = 4'(x); wr_y = 4'(y); wr_state = st;
        tick();
        wr_en = 1'b0;
    endtask

    typedef struct {
        int          h, v;
        logic        hb;
        logic [11:0] rgb;
        logic [6:0]  addr;
        logic [11:0] exp_rgb;
    } vec_t;

    vec_t tbl [0:11];

    initial begin
        int n;
        // Board after setup: EMPTY except (2,3)=SHIP, (9,0)=HIT, (0,9)=MISS.
        tbl[0]  = '{X0+69,  Y0+103, 1'b0, 12'h123, 7'h07, 12'h123};
        tbl[1]  = '{X0+85,  Y0+103, 1'b0, 12'h456, 7'h07, 12'h888};
        tbl[2]  = '{X0+320, Y0+36,  1'b0, 12'hABC, 7'h20, 12'hABC};
        tbl[3]  = '{X0+36,  Y0-1,   1'b0, 12'h321, 7'h20, 12'h321};
        tbl[4]  = '{X0+319, Y0+1,   1'b0, 12'h777, 7'h41, 12'hF00};
        tbl[5]  = '{X0+319, Y0,     1'b0, 12'h777, 7'h40, 12'h777};
        tbl[6]  = '{X0,     Y0+290, 1'b0, 12'h010, 7'h62, 12'hFFF};
        tbl[7]  = '{X0+40,  Y0+4,   1'b0, 12'h0AA, 7'h24, 12'h00F};
        tbl[8]  = '{X0+40,  Y0+4,   1'b1, 12'h0BB, 7'h24, 12'h0BB};
        tbl[9]  = '{X0-1,   Y0+4,   1'b0, 12'h0CC, 7'h20, 12'h0CC};
        tbl[10] = '{X0,     Y0+319, 1'b0, 12'h0DD, 7'h7F, 12'h0DD};
        tbl[11] = '{X0,     Y0+320, 1'b0, 12'h0EE, 7'h20, 12'h0EE};

        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; wr_x = 4'd0; wr_y = 4'd0; wr_state = 2'b00;
        hsync_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
        set_pix(0, 0, 12'h000, 1'b0);

        // Reset: every output must be zero.
        tick(); tick();
        chk("reset_outputs", 64'({rom_addr, busy, hcount_out, vcount_out, hsync_out, vsync_out,
                                  hblnk_out, vblnk_out, rgb_out}), 64'd0);
        rst = 1'b0;

        write_cell(2, 3, 2'b00);
        write_cell(9, 0, 2'b10);
        write_cell(0, 9, 2'b11);

        // Directed vectors, one per clock, checked at +1 (address) and +3 (pixel).
        for (int i = 0; i < 14; i++) begin
            if (i < 12) set_pix(tbl[i].h, tbl[i].v, tbl[i].rgb, tbl[i].hb);
            else set_pix(0, 0, 12'h000, 1'b0);
            tick();
            if (i < 12) chk($sformatf("tbl%0d_addr", i), 64'(rom_addr), 64'(tbl[i].addr));
            if (i >= 2) chk($sformatf("tbl%0d_rgb", i - 2), 64'(rgb_out), 64'(tbl[i-2].exp_rgb));
        end

        // Out-of-range write must not alias onto cell (0,1).
        write_cell(10, 0, 2'b10);
        set_pix(X0, Y0 + 32, 12'h000, 1'b0);
        tick();
        chk("bad_write", 64'(rom_addr), 64'h20);

        // Same-cycle read and write of cell 0: the pipeline sees the old state.
        set_pix(X0, Y0, 12'h000, 1'b0);
        write_cell(0, 0, 2'b10);
        chk("rw_same_old", 64'(rom_addr), 64'h20);
        tick();
        chk("rw_same_new", 64'(rom_addr), 64'h40);

        // Fill with HIT, clear, expect exactly 100 busy cycles and an all-EMPTY board.
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++) write_cell(x, y, 2'b10);
        clr = 1'b1; tick(); clr = 1'b0;
        n = busy ? 1 : 0;
        for (int g = 0; g < 400 && busy; g++) begin
            tick();
            if (busy) n++;
        end
        chk("busy_len_100", 64'(n), 64'd100);
        for (int c = 0; c < 100; c++) begin
            set_pix(X0 + (c % 10) * 32 + 3, Y0 + (c / 10) * 32, 12'h000, 1'b0);
            tick();
            chk($sformatf("cleared_%0d", c), 64'(rom_addr), 64'h20);
        end

        // Restarted clear at busy cycle 50 runs 150 cycles; a write while busy is dropped.
        clr = 1'b1; tick(); clr = 1'b0;
        n = busy ? 1 : 0;
        for (int g = 0; g < 400 && busy; g++) begin
            clr   = (n == 50);
            wr_en = (n == 140); wr_x = 4'd5; wr_y = 4'd0; wr_state = 2'b00;
            tick();
            if (busy) n++;
        end
        clr = 1'b0; wr_en = 1'b0;
        chk("busy_len_150", 64'(n), 64'd150);
        set_pix(X0 + 5 * 32, Y0, 12'h000, 1'b0);
        tick();
        chk("busy_write_dropped", 64'(rom_addr), 64'h20);

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            hcount_in = 11'($urandom_range(0, 450));
            vcount_in = 11'($urandom_range(0, 450));
            rgb_in    = 12'($urandom);
            hsync_in  = 1'($urandom);
            vsync_in  = 1'($urandom);
            hblnk_in  = ($urandom_range(0, 4) == 0);
            vblnk_in  = ($urandom_range(0, 9) == 0);
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_x      = 4'($urandom_range(0, 11));
            wr_y      = 4'($urandom_range(0, 11));
            wr_state  = 2'($urandom);
            clr       = ($urandom_range(0, 299) == 0);
            tick();
        end
        clr = 1'b0; wr_en = 1'b0;

        // Reset in the middle of a clear leaves an all-EMPTY board and idle sequencer.
        write_cell(4, 4, 2'b11);
        clr = 1'b1; tick(); clr = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("reset_midclear_busy", 64'(busy), 64'd0);
        set_pix(X0 + 4 * 32, Y0 + 4 * 32, 12'h000, 1'b0);
        tick();
        chk("reset_midclear_cell", 64'(rom_addr), 64'h20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
